src_buf: RTL and testbench
==========================

// Module: src_buf
// PURPOSE
//  Input-side ping-pong buffer; the counterpart of the output result buffer.
//  Accepts 64-bit AXI-Stream beats from DMA (S_AXIS) into one of two banks.
//  Each bank is stored as an even/odd 32-bit pair. The compute cores read 32-bit
//  words from the other, completed bank. Sits between DMA MM2S and the core array.
// PARAMETERS
//  DEPTH   32  64-bit beats per bank (power of 2); word address space = 2*DEPTH
//  AW      5   log2(DEPTH); beat index width
// PORTS
//  clk            in   1     system clock, all logic on rising edge
//  rst            in   1     asynchronous active-high reset
//  s_axis_tvalid  in   1     S_AXIS beat valid
//  s_axis_tready  out  1     S_AXIS ready (current write bank not full)
//  s_axis_tdata   in   64    S_AXIS data; [31:0]=even word, [63:32]=odd word
//  s_axis_tlast   in   1     last beat of block; closes bank early
//  bank_ready     out  1     read bank holds a completed block
//  rd_bank        out  1     index of bank currently exposed to cores
//  rd_len         out  AW+1  beats stored in read bank (1..DEPTH), valid when bank_ready
//  rd_en          in   1     read strobe (cores)
//  rd_addr        in   AW+1  32-bit word address; [0]=odd/even, [AW:1]=beat index
//  rd_data        out  32    read data, registered
//  bank_release   in   1     cores done with read bank; frees it
// BEHAVIOUR
//  Reset (async, rst=1): wr_bank=0, rd_bank=0, wr_cnt=0, full[1:0]=0, rd_len=0,
//   rd_data=0, bank_ready=0, s_axis_tready=0. Memory contents are not reset.
//  Run flag: registered, set the first clk after rst deasserts.
//   s_axis_tready = run & ~full[wr_bank]; it is combinational from registers only,
//   never from tvalid.
//  Write (accept = tvalid & tready):
//   - even[wr_bank][wr_cnt] <= tdata[31:0]; odd[wr_bank][wr_cnt] <= tdata[63:32].
//   - Bank closes when the accepted beat has wr_cnt==DEPTH-1 or tlast=1.
//     On close: full[wr_bank]<=1, len[wr_bank]<=wr_cnt+1, wr_cnt<=0, wr_bank toggles.
//   - Otherwise wr_cnt<=wr_cnt+1.
//   - A non-accepted cycle leaves wr_cnt and the bank unchanged. Holding tvalid
//     with tready=0 is legal; the data must stay stable (AXIS rule).
//  Per-bank state EMPTY -> FILLING (first beat) -> FULL (close) -> EMPTY (release).
//  Read side:
//   - bank_ready = full[rd_bank]; rd_len = len[rd_bank].
//   - rd_en=1: rd_data <= addr[0] ? odd[rd_bank][addr[AW:1]] : even[rd_bank][addr[AW:1]].
//     Latency is 1 clk. rd_data holds when rd_en=0.
//   - rd_en while bank_ready=0 returns stale memory; no error, cores must not do it.
//   - Addresses at or beyond 2*rd_len return stale data from an earlier block.
//  Release:
//   - bank_release & full[rd_bank]: full[rd_bank]<=0, rd_bank toggles.
//   - bank_release with bank_ready=0 is ignored.
//  Simultaneous events:
//   - Close of wr_bank and release of rd_bank in the same clk: both applied.
//   - If wr_bank==rd_bank (both banks were free) and the close and a release land
//     in the same cycle, release is ignored (the bank was not full) and close
//     sets full.
//   - rd_en and bank_release in the same clk: the read uses the old rd_bank.
//  Full: both banks FULL -> tready=0 until the next release. tready rises the clk
//   after release (the registered full flag clears).
//  Reset mid-block: partial bank discarded; all state returns to reset values.
// TESTING
//  1 reset then 32 beats, tdata={i+100,i}, i=0..31 -> bank0 FULL at beat 31,
//    rd_len=32; rd_addr=5 returns 102 (odd of beat2); rd_addr=4 returns 2; 1-clk latency.
//  2 tlast on beat 7 (8 beats) -> bank closes, rd_len=8, wr_bank=1, tready stays 1.
//  3 fill bank0 and bank1 with no release -> tready=0 after 64th beat; tvalid held
//    10 clk, no writes; release -> tready=1 next clk, rd_bank=1, bank_ready=1.
//  4 bank1 close on same clk as bank0 release -> full={1,0}, rd_bank=1, no beat lost.
//  5 bank_release with bank_ready=0 -> rd_bank unchanged (0), full unchanged.
//  6 assert rst after 5 beats of bank0 -> tready=0, bank_ready=0, wr_cnt=0;
//    next block starts at beat index 0 of bank0.

Source files
------------

// File: rtl/src_buf.sv
// src_buf: input-side ping-pong buffer between DMA MM2S and the core array.
// S_AXIS beats are written into the write bank as an even/odd 32-bit pair,
// while the cores read 32-bit words from the other, completed bank.
module src_buf #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tready,
    input  logic [63:0]   s_axis_tdata,
    input  logic          s_axis_tlast,
    output logic          bank_ready,
    output logic          rd_bank,
    output logic [AW:0]   rd_len,
    input  logic          rd_en,
    input  logic [AW:0]   rd_addr,
    output logic [31:0]   rd_data,
    input  logic          bank_release
);

    // Storage: [bank][beat], even word = tdata[31:0], odd word = tdata[63:32]
    logic [31:0] even_mem [0:1][0:DEPTH-1];
    logic [31:0] odd_mem  [0:1][0:DEPTH-1];

    // Control state
    logic               run;
    logic               wr_bank;
    logic [AW-1:0]      wr_cnt;
    logic [1:0]         full;
    logic [1:0][AW:0]   len_q;

    // Next-state values
    logic               wr_bank_nxt;
    logic [AW-1:0]      wr_cnt_nxt;
    logic [1:0]         full_nxt;
    logic [1:0][AW:0]   len_nxt;
    logic               rd_bank_nxt;

    logic               accept;
    logic               close;
    logic               release_ok;
    logic [AW-1:0]      rd_beat;

    // Handshake is derived from registers only, never from tvalid
    assign s_axis_tready = run & ~full[wr_bank];
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign close         = accept & ((wr_cnt == AW'(DEPTH - 1)) | s_axis_tlast);
    assign release_ok    = bank_release & full[rd_bank];
    assign bank_ready    = full[rd_bank];
    assign rd_len        = len_q[rd_bank];
    assign rd_beat       = rd_addr[AW:1];

    // Next-state logic: release is applied first so a close on the same bank wins
    always_comb begin
        wr_bank_nxt = wr_bank;
        wr_cnt_nxt  = wr_cnt;
        full_nxt    = full;
        len_nxt     = len_q;
        rd_bank_nxt = rd_bank;
        if (release_ok) begin
            full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt       = ~rd_bank;
        end
        if (close) begin
            full_nxt[wr_bank] = 1'b1;
            len_nxt[wr_bank]  = (AW+1)'(wr_cnt) + (AW+1)'(1);
            wr_cnt_nxt        = '0;
            wr_bank_nxt       = ~wr_bank;
        end else if (accept) begin
            wr_cnt_nxt = wr_cnt + AW'(1);
        end
    end

    // Control registers; a reset mid-block discards the partial bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run     <= 1'b0;
            wr_bank <= 1'b0;
            wr_cnt  <= '0;
            full    <= '0;
            len_q   <= '0;
            rd_bank <= 1'b0;
        end else begin
            run     <= 1'b1;
            wr_bank <= wr_bank_nxt;
            wr_cnt  <= wr_cnt_nxt;
            full    <= full_nxt;
            len_q   <= len_nxt;
            rd_bank <= rd_bank_nxt;
        end
    end

    // Beat write into the current write bank; memory contents are not reset
    always_ff @(posedge clk) begin
        if (accept) begin
            even_mem[wr_bank][wr_cnt] <= s_axis_tdata[31:0];
            odd_mem[wr_bank][wr_cnt]  <= s_axis_tdata[63:32];
        end
    end

    // Registered word read from the exposed bank; uses rd_bank before any release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_addr[0] ? odd_mem[rd_bank][rd_beat]
                                  : even_mem[rd_bank][rd_beat];
        end
    end

endmodule

// File: tb/tb_src_buf.sv
// Directed testbench for src_buf: fills, tlast close, backpressure, release,
// simultaneous close/release, ignored release and mid-block reset.
module tb_src_buf;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [63:0]   s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic          bank_ready;
    logic          rd_bank;
    logic [AW:0]   rd_len;
    logic          rd_en = 1'b0;
    logic [AW:0]   rd_addr = '0;
    logic [31:0]   rd_data;
    logic          bank_release = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    src_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .bank_ready    (bank_ready),
        .rd_bank       (rd_bank),
        .rd_len        (rd_len),
        .rd_en         (rd_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .bank_release  (bank_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat and hold it until accepted (bounded wait)
    task automatic push(input logic [63:0] d, input logic last);
        int n;
        n = 0;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        while (!s_axis_tready && n < 50) begin
            tick();
            n++;
        end
        if (!s_axis_tready) chk("push_timeout", 64'd0, 64'd1);
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic rd(input logic [AW:0] a, output logic [31:0] d);
        rd_en   = 1'b1;
        rd_addr = a;
        tick();
        rd_en = 1'b0;
        d     = rd_data;
    endtask

    logic [31:0] d;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_tready", s_axis_tready, 0);
        chk("rst_bank_ready", bank_ready, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_rd_len", rd_len, 0);
        chk("rst_rd_data", rd_data, 0);
        rst = 1'b0;
        tick();
        chk("run_tready", s_axis_tready, 1);

        // Release with nothing ready is ignored
        bank_release = 1'b1;
        tick();
        bank_release = 1'b0;
        chk("t5_rd_bank", rd_bank, 0);
        chk("t5_bank_ready", bank_ready, 0);
        chk("t5_tready", s_axis_tready, 1);

        // Test 1: 32 beats {i+100, i} fill bank0
        for (int i = 0; i < 31; i++) push({32'(i + 100), 32'(i)}, 1'b0);
        chk("t1_not_ready", bank_ready, 0);
        push({32'd131, 32'd31}, 1'b0);
        chk("t1_bank_ready", bank_ready, 1);
        chk("t1_rd_len", rd_len, 32);
        chk("t1_rd_bank", rd_bank, 0);
        chk("t1_tready", s_axis_tready, 1);
        rd(6'd5, d);
        chk("t1_addr5", d, 102);
        rd(6'd4, d);
        chk("t1_addr4", d, 2);
        rd_en   = 1'b1;
        rd_addr = 6'd63;
        #1;
        chk("t1_lat_pre", rd_data, 2);
        tick();
        chk("t1_lat_post", rd_data, 131);
        rd_en   = 1'b0;
        rd_addr = 6'd5;
        tick();
        chk("t1_hold", rd_data, 131);

        // Free bank0, then Test 2: tlast on beat 7 closes bank1 early
        bank_release = 1'b1;
        tick();
        bank_release = 1'b0;
        chk("t2_rel_rd_bank", rd_bank, 1);
        chk("t2_rel_not_ready", bank_ready, 0);
        for (int i = 0; i < 8; i++) push({32'(200 + i), 32'(50 + i)}, i == 7);
        chk("t2_bank_ready", bank_ready, 1);
        chk("t2_rd_len", rd_len, 8);
        chk("t2_tready", s_axis_tready, 1);
        rd(6'd15, d);
        chk("t2_addr15", d, 207);
        rd(6'd0, d);
        chk("t2_addr0", d, 50);

        // Test 3: fill bank0 too; both full -> backpressure
        for (int i = 0; i < 32; i++) push({32'(300 + i), 32'(400 + i)}, 1'b0);
        chk("t3_full_tready", s_axis_tready, 0);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t3_held_tready", s_axis_tready, 0);
        end
        s_axis_tvalid = 1'b0;
        bank_release  = 1'b1;
        tick();
        bank_release = 1'b0;
        chk("t3_rel_tready", s_axis_tready, 1);
        chk("t3_rel_rd_bank", rd_bank, 0);
        chk("t3_rel_bank_ready", bank_ready, 1);
        chk("t3_rel_rd_len", rd_len, 32);
        rd(6'd0, d);
        chk("t3_addr0", d, 400);
        rd(6'd63, d);
        chk("t3_addr63", d, 331);

        // Test 4: bank1 close on the same clk as bank0 release (with a read)
        for (int i = 0; i < 7; i++) push({32'(500 + i), 32'(600 + i)}, 1'b0);
        chk("t4_pre_tready", s_axis_tready, 1);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = {32'd507, 32'd607};
        s_axis_tlast  = 1'b1;
        bank_release  = 1'b1;
        rd_en         = 1'b1;
        rd_addr       = 6'd0;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        bank_release  = 1'b0;
        rd_en         = 1'b0;
        chk("t4_read_old_bank", rd_data, 400);
        chk("t4_rd_bank", rd_bank, 1);
        chk("t4_bank_ready", bank_ready, 1);
        chk("t4_rd_len", rd_len, 8);
        chk("t4_tready", s_axis_tready, 1);
        rd(6'd0, d);
        chk("t4_addr0", d, 600);
        rd(6'd1, d);
        chk("t4_addr1", d, 500);
        rd(6'd15, d);
        chk("t4_addr15", d, 507);

        // Test 6: async reset after 5 beats into bank0
        for (int i = 0; i < 5; i++) push({32'(700 + i), 32'(800 + i)}, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_tready", s_axis_tready, 0);
        chk("t6_bank_ready", bank_ready, 0);
        chk("t6_rd_bank", rd_bank, 0);
        chk("t6_rd_len", rd_len, 0);
        chk("t6_rd_data", rd_data, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_run_tready", s_axis_tready, 1);
        push({32'd900, 32'd901}, 1'b0);
        push({32'd910, 32'd911}, 1'b1);
        chk("t6_bank_ready2", bank_ready, 1);
        chk("t6_rd_bank2", rd_bank, 0);
        chk("t6_rd_len2", rd_len, 2);
        rd(6'd0, d);
        chk("t6_addr0", d, 901);
        rd(6'd3, d);
        chk("t6_addr3", d, 910);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
